clk_div_ctrl: RTL
=================

# clk_div_ctrl

Run-time controller for the board's square-wave clock divider. It holds a programmable half-period count and starts, stops or single-shots the divided output. Ratio changes land only on half-period boundaries, so `clk_out` never glitches. It sits between the front-panel/command logic and the slow-clock consumers (display refresh, debouncers), replacing the fixed 100 MHz -> 500 Hz divide.

## Interface
- `CNT_W`, 32: width of the half-period count and internal counter.
- `DEFAULT_HALF`, 100000: half-period, in `clk_in` cycles, loaded at reset (500 Hz from 100 MHz).
- `clk_in` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: command request.
- `cfg_ready` out 1: command can be accepted.
- `cfg_op` in 2: 00 SET_HALF, 01 START, 10 STOP, 11 SINGLE.
- `cfg_half` in CNT_W: new half-period; used by SET_HALF only.
- `clk_out` out 1: divided square wave.
- `tick` out 1: one-cycle pulse in the same cycle `clk_out` goes 0->1.
- `running` out 1: high when the state is not IDLE.
- `half_active` out CNT_W: half-period currently in force.
- `cfg_err` out 1: one-cycle pulse when a command is rejected.

## Operation
- **States:** IDLE, RUN, SINGLE, DRAIN.
- **Counter:** `cnt` counts 0..`half_active`-1 while not IDLE. When `cnt == half_active-1`:
  - toggle `clk_out` and clear `cnt`;
  - this is a boundary; half-period = `half_active` cycles.
- **Handshake:**
  - A command is accepted when `cfg_valid && cfg_ready`.
  - `cfg_ready = !pending`.
  - Requester holds `cfg_op`/`cfg_half` stable until accepted.
- **SET_HALF:**
  - `cfg_half == 0`: rejected; `cfg_err` pulses and nothing changes.
  - In IDLE: `half_active` updates on the next cycle.
  - Otherwise: value goes to a shadow register and `pending` is set. At the next boundary `half_active` loads the shadow and `pending` clears.
- **START:**
  - IDLE -> RUN with `cnt` = 0 and `clk_out` = 0; first rising edge comes `half_active` cycles after accept.
  - From SINGLE/DRAIN -> RUN with no phase change.
  - In RUN: accepted, no effect.
- **STOP:**
  - In RUN/SINGLE with `clk_out` = 0 (post-boundary value): -> IDLE immediately; `cnt` clears.
  - With `clk_out` = 1: -> DRAIN.
  - DRAIN -> IDLE at the falling boundary.
  - In IDLE: accepted, no effect.
- **SINGLE:**
  - From IDLE: one full period. High at N cycles, low at 2N cycles (N = `half_active`), then IDLE.
  - In RUN: -> DRAIN-equivalent, finishing the current period.
- **Outputs:** `clk_out` is always 0 in IDLE; it only goes high→low at a boundary, never mid-half.
- **Reset mid-operation:** asynchronous return to reset values; shadow and `pending` are discarded.

## Timing
- **Reset values:**
  - `clk_out`, `tick`, `running`, `cfg_err` = 0;
  - `cfg_ready` = 1;
  - `half_active` = `DEFAULT_HALF`;
  - state = IDLE, `cnt` = 0.
- All outputs are registered. Command effects appear the cycle after accept.
- **Same-cycle boundary and command:**
  - The boundary toggle and shadow load happen first.
  - STOP decides using the post-toggle `clk_out`.
  - A SET_HALF cannot coincide with a pending load, because `cfg_ready` = 0.
- `tick` never asserts in IDLE. `cfg_err` and `tick` last one cycle each.
- **Width:** `cnt` and the compare are CNT_W unsigned. `half_active` = 1 gives toggling every cycle.

## Structure
- Package `clk_div_pkg`: `cfg_op` encodings, state enum, `DEFAULT_HALF` constant.
- One sub-module, `clk_div_counter`:
  - contains the loadable half-period counter with toggle, boundary strobe and shadow load;
  - `clk_div_ctrl` contains the FSM and handshake.

## Test plan
- **Reset, then START** (DEFAULT_HALF = 4): `clk_out` rises 4 cycles after accept and falls 8 cycles after; `tick` pulses once per period; `running` = 1.
- **SET_HALF = 2 issued mid-high-half** while running at 4: `cfg_ready` = 0 until the next boundary; all later halves are 2 cycles; no half shorter than the one in progress.
- **STOP while `clk_out` = 1:** DRAIN, falling edge at the normal boundary, then `running` = 0 with `clk_out` held 0. **STOP while low:** IDLE next cycle.
- **SINGLE from IDLE with half = 3:** high at cycles 3–5, low from cycle 6, `running` = 0; exactly one `tick`.
- **SET_HALF = 0:** one-cycle `cfg_err`; `half_active` unchanged. **SET_HALF = 5 in IDLE:** `half_active` = 5 the next cycle.
- **`reset_n` asserted mid-run with an update pending:** all outputs return to reset values immediately; the shadow value is never applied after release.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared encodings and defaults for the run-time square-wave clock divider.
package clk_div_pkg;

  localparam int unsigned DEFAULT_HALF = 100000;

  typedef enum logic [1:0] {
    OP_SET_HALF = 2'b00,
    OP_START    = 2'b01,
    OP_STOP     = 2'b10,
    OP_SINGLE   = 2'b11
  } cfg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SINGLE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/clk_div_counter.sv
// Loadable half-period counter: toggles clk_out on each boundary and applies
// a shadowed half-period only at a boundary (or straight away once idle).
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clear,
  input  logic             set_direct,
  input  logic             shadow_wr,
  input  logic [CNT_W-1:0] half_in,
  output logic             boundary,
  output logic             clk_next,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic [CNT_W-1:0] half_active
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;

  assign boundary = run && (cnt == half_active - CNT_W'(1));
  assign clk_next = boundary ? ~clk_out : clk_out;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= boundary && !clk_out && !clear;
      if (clear) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (boundary) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A pending value left over when the divider drops to idle is applied at once
  // so the handshake can never stall with nothing left to reach a boundary.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      half_active <= RESET_HALF;
      shadow      <= '0;
      pending     <= 1'b0;
    end else begin
      if (set_direct) begin
        half_active <= half_in;
      end else if (pending && (boundary || !run)) begin
        half_active <= shadow;
        pending     <= 1'b0;
      end
      if (shadow_wr) begin
        shadow  <= half_in;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the square-wave clock divider: command handshake
// and start/stop/single-shot sequencing around clk_div_counter.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_op,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] half_active,
  output logic             cfg_err
);

  state_e state, state_next;
  logic   accept;
  logic   pending;
  logic   boundary;
  logic   clk_next;
  logic   clear;
  logic   set_direct;
  logic   shadow_wr;
  logic   err_next;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && cfg_ready;

  clk_div_counter #(
    .CNT_W      (CNT_W),
    .RESET_HALF (CNT_W'(DEFAULT_HALF))
  ) u_counter (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .run         (state != ST_IDLE),
    .clear       (clear),
    .set_direct  (set_direct),
    .shadow_wr   (shadow_wr),
    .half_in     (cfg_half),
    .boundary    (boundary),
    .clk_next    (clk_next),
    .clk_out     (clk_out),
    .tick        (tick),
    .pending     (pending),
    .half_active (half_active)
  );

  // Decisions use clk_next, the level after this cycle's boundary toggle.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    set_direct = 1'b0;
    shadow_wr  = 1'b0;
    err_next   = 1'b0;
    if ((state == ST_SINGLE || state == ST_DRAIN) && boundary && clk_out)
      state_next = ST_IDLE;
    if (accept) begin
      case (cfg_op_e'(cfg_op))
        OP_SET_HALF: begin
          if (cfg_half == '0)
            err_next = 1'b1;
          else if (state == ST_IDLE)
            set_direct = 1'b1;
          else
            shadow_wr = 1'b1;
        end
        OP_START: begin
          if (state == ST_IDLE)
            clear = 1'b1;
          state_next = ST_RUN;
        end
        OP_STOP: begin
          if (state == ST_RUN || state == ST_SINGLE)
            state_next = clk_next ? ST_DRAIN : ST_IDLE;
        end
        OP_SINGLE: begin
          if (state == ST_IDLE) begin
            state_next = ST_SINGLE;
            clear      = 1'b1;
          end else if (state == ST_RUN) begin
            state_next = clk_next ? ST_DRAIN : ST_SINGLE;
          end
        end
        default: ;
      endcase
    end
    if (state != ST_IDLE && state_next == ST_IDLE)
      clear = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next != ST_IDLE);
      cfg_err <= err_next;
    end
  end

endmodule
